render_setup: RTL and testbench

Per-frame geometry setup for the tangram renderer. At frame start it walks the piece table and converts each piece's pixel position and rotation index into the fixed-point start point and step values (`ix`, `iy`, `sin`, `cos`) that the per-piece `render_shape` rasterisers load on `newframe`. It sits between the piece-state registers and the `render_shape` parameter registers. It runs once per frame, inside vertical blanking, with one shared multiplier.

---
 rtl/render_setup.sv | 259 +++++++++++++++++++++++++
 tb/tb_render_setup.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_setup.sv
// Per-frame table walk turning piece position/rotation into render_shape start point and step values.
// Build macro RENDER_SETUP_HIDE_EN adds per-piece visibility (piece_vis in, wr_vis out).
module render_setup #(
  parameter int PIECES         = 7,
  parameter int ANGLE_BITS     = 4,
  parameter int INT_BITS       = 10,
  parameter int FLOAT_BITS     = 20,
  parameter int FLOAT_DCM_BITS = 8,
  localparam int IDX_W         = (PIECES > 1) ? $clog2(PIECES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             rd_idx,
  input  logic [INT_BITS-1:0]          piece_px,
  input  logic [INT_BITS-1:0]          piece_py,
  input  logic [ANGLE_BITS-1:0]        piece_rot,
`ifdef RENDER_SETUP_HIDE_EN
  input  logic                         piece_vis,
  output logic                         wr_vis,
`endif
  output logic                         wr_en,
  output logic [IDX_W-1:0]             wr_idx,
  output logic signed [FLOAT_BITS-1:0] ix,
  output logic signed [FLOAT_BITS-1:0] iy,
  output logic signed [FLOAT_BITS-1:0] sin,
  output logic signed [FLOAT_BITS-1:0] cos
);

  // Angle index is rescaled onto a 64-step circle, so ANGLE_BITS may range from 2 to 6.
  localparam int SH = 6 - ANGLE_BITS;

  typedef enum logic [3:0] {
    ST_IDLE, ST_READ, ST_LUT, ST_MUL0, ST_MUL1, ST_MUL2, ST_MUL3, ST_WRITE, ST_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;
  logic [INT_BITS-1:0]          px_q, px_d, py_q, py_d;
  logic signed [FLOAT_BITS-1:0] sin_l_q, sin_l_d, cos_l_q, cos_l_d;
  logic signed [FLOAT_BITS-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [FLOAT_BITS-1:0] ix_q, ix_d, iy_q, iy_d, sin_q, sin_d, cos_q, cos_d;
`ifdef RENDER_SETUP_HIDE_EN
  logic                         wr_vis_q, wr_vis_d;
`endif

  logic [5:0]                   lut_k;
  logic [4:0]                   lut_f;
  logic [16:0]                  lut_s_f, lut_s_c;
  logic signed [FLOAT_BITS-1:0] lut_sin, lut_cos;

  logic [INT_BITS-1:0]          mul_a;
  logic signed [FLOAT_BITS-1:0] mul_a_s, mul_b, mul_term;

  // First quadrant of sine in Q16 at 5.625 degree steps.
  function automatic logic [16:0] qsin16(input logic [4:0] k);
    logic [16:0] v;
    case (k)
      5'd0:    v = 17'd0;
      5'd1:    v = 17'd6424;
      5'd2:    v = 17'd12785;
      5'd3:    v = 17'd19024;
      5'd4:    v = 17'd25079;
      5'd5:    v = 17'd30894;
      5'd6:    v = 17'd36410;
      5'd7:    v = 17'd41576;
      5'd8:    v = 17'd46341;
      5'd9:    v = 17'd50660;
      5'd10:   v = 17'd54491;
      5'd11:   v = 17'd57798;
      5'd12:   v = 17'd60547;
      5'd13:   v = 17'd62714;
      5'd14:   v = 17'd64277;
      5'd15:   v = 17'd65220;
      default: v = 17'd65536;
    endcase
    return v;
  endfunction

  function automatic logic signed [FLOAT_BITS-1:0] to_fixed(input logic [16:0] q, input logic neg);
    logic [17:0]                  r;
    logic signed [FLOAT_BITS-1:0] m;
    r = ({1'b0, q} + (18'd1 << (15 - FLOAT_DCM_BITS))) >> (16 - FLOAT_DCM_BITS);
    m = FLOAT_BITS'(r);
    return neg ? -m : m;
  endfunction

  always_comb begin
    lut_k   = 6'(piece_rot) << SH;
    lut_f   = {1'b0, lut_k[3:0]};
    lut_s_f = qsin16(lut_f);
    lut_s_c = qsin16(5'd16 - lut_f);
    case (lut_k[5:4])
      2'd0: begin
        lut_sin = to_fixed(lut_s_f, 1'b0);
        lut_cos = to_fixed(lut_s_c, 1'b0);
      end
      2'd1: begin
        lut_sin = to_fixed(lut_s_c, 1'b0);
        lut_cos = to_fixed(lut_s_f, 1'b1);
      end
      2'd2: begin
        lut_sin = to_fixed(lut_s_f, 1'b1);
        lut_cos = to_fixed(lut_s_c, 1'b1);
      end
      default: begin
        lut_sin = to_fixed(lut_s_c, 1'b1);
        lut_cos = to_fixed(lut_s_f, 1'b0);
      end
    endcase
  end

  // Only the low FLOAT_BITS of the full product survive the wrap, so only those are formed.
  assign mul_a_s  = FLOAT_BITS'({1'b0, mul_a});
  assign mul_term = mul_a_s * mul_b;

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    px_d     = px_q;
    py_d     = py_q;
    sin_l_d  = sin_l_q;
    cos_l_d  = cos_l_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    sin_d    = sin_q;
    cos_d    = cos_q;
`ifdef RENDER_SETUP_HIDE_EN
    wr_vis_d = wr_vis_q;
`endif
    mul_a    = px_q;
    mul_b    = cos_l_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_idx_d = '0;
          state_d  = ST_READ;
        end
      end
      ST_READ: state_d = ST_LUT;
      ST_LUT: begin
        px_d    = piece_px;
        py_d    = piece_py;
        sin_l_d = lut_sin;
        cos_l_d = lut_cos;
        state_d = ST_MUL0;
`ifdef RENDER_SETUP_HIDE_EN
        if (!piece_vis) begin
          ix_d     = '0;
          iy_d     = '0;
          sin_d    = '0;
          cos_d    = '0;
          wr_vis_d = 1'b0;
          wr_idx_d = rd_idx_q;
          state_d  = ST_WRITE;
        end
`endif
      end
      ST_MUL0: begin
        mul_a   = px_q;
        mul_b   = cos_l_q;
        acc_x_d = -mul_term;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        mul_a   = py_q;
        mul_b   = sin_l_q;
        acc_x_d = acc_x_q + mul_term;
        state_d = ST_MUL2;
      end
      ST_MUL2: begin
        mul_a   = px_q;
        mul_b   = sin_l_q;
        acc_y_d = -mul_term;
        state_d = ST_MUL3;
      end
      ST_MUL3: begin
        mul_a    = py_q;
        mul_b    = cos_l_q;
        ix_d     = acc_x_q;
        iy_d     = acc_y_q - mul_term;
        sin_d    = sin_l_q;
        cos_d    = cos_l_q;
        wr_idx_d = rd_idx_q;
`ifdef RENDER_SETUP_HIDE_EN
        wr_vis_d = 1'b1;
`endif
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (rd_idx_q == IDX_W'(PIECES - 1)) begin
          state_d = ST_DONE;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      px_q     <= '0;
      py_q     <= '0;
      sin_l_q  <= '0;
      cos_l_q  <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      ix_q     <= '0;
      iy_q     <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      px_q     <= px_d;
      py_q     <= py_d;
      sin_l_q  <= sin_l_d;
      cos_l_q  <= cos_l_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      sin_q    <= sin_d;
      cos_q    <= cos_d;
    end
  end

`ifdef RENDER_SETUP_HIDE_EN
  always_ff @(posedge clk) begin
    if (rst) wr_vis_q <= 1'b0;
    else     wr_vis_q <= wr_vis_d;
  end
  assign wr_vis = wr_vis_q;
`endif

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign wr_en  = (state_q == ST_WRITE);
  assign rd_idx = rd_idx_q;
  assign wr_idx = wr_idx_q;
  assign ix     = ix_q;
  assign iy     = iy_q;
  assign sin    = sin_q;
  assign cos    = cos_q;

endmodule

// File: tb/tb_render_setup.sv
// Directed bench for render_setup: reset, quarter angles, full walk, restart rules, mid-walk reset.
// Honours RENDER_SETUP_HIDE_EN to exercise the visibility build.
module tb_render_setup;
  localparam int PIECES = 7;
  localparam int AB     = 4;
  localparam int IB     = 10;
  localparam int FB     = 18;
  localparam int DCM    = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done, wr_en;
  logic [2:0] rd_idx, wr_idx;
  logic [IB-1:0] piece_px, piece_py;
  logic [AB-1:0] piece_rot;
  logic signed [FB-1:0] ix, iy, s_out, c_out;
`ifdef RENDER_SETUP_HIDE_EN
  logic piece_vis, wr_vis;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [IB-1:0] t_px [PIECES];
  logic [IB-1:0] t_py [PIECES];
  logic [AB-1:0] t_rot[PIECES];
  logic          t_vis[PIECES];

  render_setup #(
    .PIECES(PIECES), .ANGLE_BITS(AB), .INT_BITS(IB), .FLOAT_BITS(FB), .FLOAT_DCM_BITS(DCM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_idx(rd_idx),
    .piece_px(piece_px), .piece_py(piece_py), .piece_rot(piece_rot),
`ifdef RENDER_SETUP_HIDE_EN
    .piece_vis(piece_vis), .wr_vis(wr_vis),
`endif
    .wr_en(wr_en), .wr_idx(wr_idx), .ix(ix), .iy(iy), .sin(s_out), .cos(c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Piece table with one cycle of read latency.
  always @(posedge clk) begin
    piece_px  <= t_px[rd_idx];
    piece_py  <= t_py[rd_idx];
    piece_rot <= t_rot[rd_idx];
`ifdef RENDER_SETUP_HIDE_EN
    piece_vis <= t_vis[rd_idx];
`endif
  end

  typedef struct {int c; int idx; int ix; int iy; int s; int co; int vis;} wr_t;
  wr_t wq[$];

  always @(negedge clk) begin : mon
    wr_t w;
    if (wr_en === 1'b1) begin
      w.c   = cyc;
      w.idx = int'(wr_idx);
      w.ix  = int'(ix);
      w.iy  = int'(iy);
      w.s   = int'(s_out);
      w.co  = int'(c_out);
`ifdef RENDER_SETUP_HIDE_EN
      w.vis = int'(wr_vis);
`else
      w.vis = 1;
`endif
      wq.push_back(w);
      $display("[cyc %0d] write idx=%0d ix=%0d iy=%0d sin=%0d cos=%0d vis=%0d",
               w.c, w.idx, w.ix, w.iy, w.s, w.co, w.vis);
    end
  end

  // round(256*sin(r*22.5 deg))
  function automatic int sin_ref(input int r);
    case (r & 15)
      0: return 0;     1: return 98;    2: return 181;   3: return 237;
      4: return 256;   5: return 237;   6: return 181;   7: return 98;
      8: return 0;     9: return -98;   10: return -181; 11: return -237;
      12: return -256; 13: return -237; 14: return -181; default: return -98;
    endcase
  endfunction

  function automatic int cos_ref(input int r);
    return sin_ref(r + 4);
  endfunction

  function automatic int wrap(input longint v);
    logic signed [FB-1:0] t;
    t = v[FB-1:0];
    return int'(t);
  endfunction

  function automatic int ix_ref(input int px, input int py, input int r);
    return wrap(-longint'(px) * cos_ref(r) + longint'(py) * sin_ref(r));
  endfunction

  function automatic int iy_ref(input int px, input int py, input int r);
    return wrap(-longint'(px) * sin_ref(r) - longint'(py) * cos_ref(r));
  endfunction

  task automatic start_walk(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    n_cmp++;
    if (dc < 0) begin
      n_err++;
      $display("FAIL %s_timeout: done not seen within %0d cycles, required a done pulse", nm, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, wr_en} !== 3'b000 || rd_idx !== 3'd0 || wr_idx !== 3'd0 ||
          ix !== '0 || iy !== '0 || s_out !== '0 || c_out !== '0) begin
        n_err++;
        $display("FAIL reset_idle: cyc %0d busy=%b done=%b wr_en=%b rd=%0d wr=%0d ix=%0d iy=%0d sin=%0d cos=%0d, required all 0",
                 cyc, busy, done, wr_en, rd_idx, wr_idx, ix, iy, s_out, c_out);
      end
    end
  endtask

  task automatic run_single(input string nm, input int rot, input int es, input int ec,
                            input int eix, input int eiy, output wr_t w);
    int t, dc;
    for (int i = 0; i < PIECES; i++) begin
      t_px[i] = IB'(i); t_py[i] = IB'(i); t_rot[i] = '0; t_vis[i] = 1'b1;
    end
    t_px[0] = 10'd100; t_py[0] = 10'd50; t_rot[0] = AB'(rot);
    wq.delete();
    start_walk(t);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s_busy_t1: busy=%b, required 1", nm, busy);
    end
    wait_done(nm, 100, dc);
    n_cmp++;
    if (dc != t + 50) begin
      n_err++; $display("FAIL %s_done_time: done at T+%0d, required T+50", nm, dc - t);
    end
    w = '{default: 0};
    n_cmp++;
    if (wq.size() == 0) begin
      n_err++; $display("FAIL %s_no_write: got 0 writes, required 7", nm);
    end else begin
      w = wq[0];
      n_cmp += 6;
      if (w.c != t + 7) begin n_err++; $display("FAIL %s_wr_time: T+%0d, required T+7", nm, w.c - t); end
      if (w.idx != 0)   begin n_err++; $display("FAIL %s_wr_idx: %0d, required 0", nm, w.idx); end
      if (w.s != es)    begin n_err++; $display("FAIL %s_sin: %0d, required %0d", nm, w.s, es); end
      if (w.co != ec)   begin n_err++; $display("FAIL %s_cos: %0d, required %0d", nm, w.co, ec); end
      if (w.ix != eix)  begin n_err++; $display("FAIL %s_ix: %0d, required %0d", nm, w.ix, eix); end
      if (w.iy != eiy)  begin n_err++; $display("FAIL %s_iy: %0d, required %0d", nm, w.iy, eiy); end
    end
  endtask

  task automatic test_angle0();
    wr_t w;
    run_single("angle0", 0, 0, 256, -25600, -12800, w);
  endtask

  task automatic test_angle90();
    wr_t w;
    int x, y;
    run_single("angle90", 4, 256, 0, 12800, -25600, w);
    x = w.ix + 100 * w.co - 50 * w.s;
    y = w.iy + 100 * w.s + 50 * w.co;
    n_cmp++;
    if (x != 0 || y != 0) begin
      n_err++; $display("FAIL angle90_roundtrip: x=%0d y=%0d, required 0 0", x, y);
    end
  endtask

  task automatic test_full_walk();
    int px[PIECES]  = '{17, 1023, 640, 3, 900, 256, 511};
    int py[PIECES]  = '{400, 1023, 12, 777, 300, 0, 480};
    int rot[PIECES] = '{1, 2, 3, 5, 7, 10, 15};
    int t, dc;
    for (int i = 0; i < PIECES; i++) begin
      t_px[i] = IB'(px[i]); t_py[i] = IB'(py[i]); t_rot[i] = AB'(rot[i]); t_vis[i] = 1'b1;
    end
    wq.delete();
    start_walk(t);
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (cyc == t + 20);
      if (done === 1'b1) begin dc = cyc; break; end
    end
    start = 1'b0;
    n_cmp += 2;
    if (dc != t + 50) begin n_err++; $display("FAIL walk_done_time: T+%0d, required T+50", dc - t); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL walk_busy_at_done: busy=%b, required 0", busy); end
    // A start presented while done is high must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL walk_start_in_done: busy=%b, required 0", busy); end
    if (wq.size() != PIECES) begin n_err++; $display("FAIL walk_count: %0d writes, required %0d", wq.size(), PIECES); end
    for (int i = 0; i < PIECES && i < wq.size(); i++) begin
      n_cmp += 6;
      if (wq[i].idx != i) begin n_err++; $display("FAIL walk_idx%0d: %0d, required %0d", i, wq[i].idx, i); end
      if (wq[i].c != t + 7 * (i + 1)) begin
        n_err++; $display("FAIL walk_time%0d: T+%0d, required T+%0d", i, wq[i].c - t, 7 * (i + 1));
      end
      if (wq[i].s != sin_ref(rot[i])) begin n_err++; $display("FAIL walk_sin%0d: %0d, required %0d", i, wq[i].s, sin_ref(rot[i])); end
      if (wq[i].co != cos_ref(rot[i])) begin n_err++; $display("FAIL walk_cos%0d: %0d, required %0d", i, wq[i].co, cos_ref(rot[i])); end
      if (wq[i].ix != ix_ref(px[i], py[i], rot[i])) begin
        n_err++; $display("FAIL walk_ix%0d: %0d, required %0d", i, wq[i].ix, ix_ref(px[i], py[i], rot[i]));
      end
      if (wq[i].iy != iy_ref(px[i], py[i], rot[i])) begin
        n_err++; $display("FAIL walk_iy%0d: %0d, required %0d", i, wq[i].iy, iy_ref(px[i], py[i], rot[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, dc, late, seen_done;
    late = 0;
    seen_done = 0;
    wq.delete();
    start_walk(t);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      rst = (cyc == t + 24);
      if (done === 1'b1) seen_done = 1;
    end
    rst = 1'b0;
    foreach (wq[i]) if (wq[i].c > t + 24) late++;
    n_cmp += 4;
    if (late != 0) begin n_err++; $display("FAIL rstmid_late_write: %0d writes after T+24, required 0", late); end
    if (seen_done != 0) begin n_err++; $display("FAIL rstmid_done: done seen, required none"); end
    if (wq.size() != 3) begin n_err++; $display("FAIL rstmid_count: %0d writes, required 3", wq.size()); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: busy=%b, required 0", busy); end
    wq.delete();
    start_walk(t);
    wait_done("rstmid_restart", 100, dc);
    n_cmp += 2;
    if (dc != t + 50) begin n_err++; $display("FAIL rstmid_restart_time: T+%0d, required T+50", dc - t); end
    if (wq.size() != PIECES) begin n_err++; $display("FAIL rstmid_restart_count: %0d, required %0d", wq.size(), PIECES); end
  endtask

  task automatic test_rst_start_same();
    wq.delete();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_start_busy: busy=%b, required 0", busy); end
    if (wq.size() != 0) begin n_err++; $display("FAIL rst_start_writes: %0d, required 0", wq.size()); end
  endtask

`ifdef RENDER_SETUP_HIDE_EN
  task automatic test_hide();
    int px[PIECES]  = '{100, 200, 300, 400, 500, 600, 700};
    int py[PIECES]  = '{50, 60, 70, 80, 90, 110, 120};
    int rot[PIECES] = '{0, 4, 2, 6, 9, 12, 14};
    int tm[PIECES]  = '{7, 10, 17, 20, 27, 34, 41};
    int t, dc, ev, eix, eiy, es, ec;
    for (int i = 0; i < PIECES; i++) begin
      t_px[i] = IB'(px[i]); t_py[i] = IB'(py[i]); t_rot[i] = AB'(rot[i]);
      t_vis[i] = !(i == 1 || i == 3);
    end
    wq.delete();
    start_walk(t);
    wait_done("hide", 100, dc);
    n_cmp += 2;
    if (dc != t + 42) begin n_err++; $display("FAIL hide_done_time: T+%0d, required T+42", dc - t); end
    if (wq.size() != PIECES) begin n_err++; $display("FAIL hide_count: %0d, required %0d", wq.size(), PIECES); end
    for (int i = 0; i < PIECES && i < wq.size(); i++) begin
      ev  = (i == 1 || i == 3) ? 0 : 1;
      es  = ev ? sin_ref(rot[i]) : 0;
      ec  = ev ? cos_ref(rot[i]) : 0;
      eix = ev ? ix_ref(px[i], py[i], rot[i]) : 0;
      eiy = ev ? iy_ref(px[i], py[i], rot[i]) : 0;
      n_cmp++;
      if (wq[i].c != t + tm[i] || wq[i].vis != ev || wq[i].s != es || wq[i].co != ec ||
          wq[i].ix != eix || wq[i].iy != eiy) begin
        n_err++;
        $display("FAIL hide_wr%0d: T+%0d vis=%0d sin=%0d cos=%0d ix=%0d iy=%0d, required T+%0d vis=%0d sin=%0d cos=%0d ix=%0d iy=%0d",
                 i, wq[i].c - t, wq[i].vis, wq[i].s, wq[i].co, wq[i].ix, wq[i].iy,
                 tm[i], ev, es, ec, eix, eiy);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < PIECES; i++) begin
      t_px[i] = '0; t_py[i] = '0; t_rot[i] = '0; t_vis[i] = 1'b1;
    end
    test_reset();
    test_angle0();
    test_angle90();
    test_full_walk();
    test_reset_mid();
    test_rst_start_same();
`ifdef RENDER_SETUP_HIDE_EN
    test_hide();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
